// File: rtl/key_entry_sequencer.sv
// Turns a stream of PS/2 scan bytes into "letter, digit, Enter" commands for the game logic.
// Break and extended sequences are filtered out. Backspace and Esc edit the entry in progress.
module key_entry_sequencer #(
    parameter int TIMEOUT_CYCLES = 27000000,
    parameter int TW             = 25
) (
    input  logic       clock27,
    input  logic       reset,
    input  logic       scan_valid,
    input  logic [7:0] scan_code,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic [3:0] cmd_letter,
    output logic [3:0] cmd_number,
    output logic [1:0] entry_state,
    output logic       entry_err,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        GOT_LETTER = 2'd1,
        GOT_NUMBER = 2'd2,
        HOLD       = 2'd3
    } state_t;

    localparam logic [7:0] KEY_BREAK    = 8'hF0;
    localparam logic [7:0] KEY_EXTENDED = 8'hE0;
    localparam logic [7:0] KEY_ENTER    = 8'h5A;
    localparam logic [7:0] KEY_BKSP     = 8'h66;
    localparam logic [7:0] KEY_ESC      = 8'h76;

    // {hit, index}: hit is set when the byte is one of the letter keys A..J
    function automatic logic [4:0] letter_decode(input logic [7:0] code);
        case (code)
            8'h1C:   return {1'b1, 4'd0};
            8'h32:   return {1'b1, 4'd1};
            8'h21:   return {1'b1, 4'd2};
            8'h23:   return {1'b1, 4'd3};
            8'h24:   return {1'b1, 4'd4};
            8'h2B:   return {1'b1, 4'd5};
            8'h34:   return {1'b1, 4'd6};
            8'h33:   return {1'b1, 4'd7};
            8'h43:   return {1'b1, 4'd8};
            8'h3B:   return {1'b1, 4'd9};
            default: return 5'd0;
        endcase
    endfunction

    function automatic logic [4:0] digit_decode(input logic [7:0] code);
        case (code)
            8'h45:   return {1'b1, 4'd0};
            8'h16:   return {1'b1, 4'd1};
            8'h1E:   return {1'b1, 4'd2};
            8'h26:   return {1'b1, 4'd3};
            8'h25:   return {1'b1, 4'd4};
            8'h2E:   return {1'b1, 4'd5};
            8'h36:   return {1'b1, 4'd6};
            8'h3D:   return {1'b1, 4'd7};
            8'h3E:   return {1'b1, 4'd8};
            8'h46:   return {1'b1, 4'd9};
            default: return 5'd0;
        endcase
    endfunction

    state_t        state;
    logic          brk;
    logic          ext;
    logic [TW-1:0] idle_cnt;

    logic       is_prefix;
    logic       make_code;
    logic [4:0] letter_d;
    logic [4:0] digit_d;
    logic       is_letter;
    logic       is_digit;
    logic       is_enter;
    logic       is_bksp;
    logic       is_esc;
    logic       entry_open;
    logic       timeout_hit;

    assign is_prefix = (scan_code == KEY_BREAK) || (scan_code == KEY_EXTENDED);
    // Only a clean make code reaches the FSM. A byte that follows a prefix is the tail of a break or extended sequence.
    assign make_code = scan_valid && !is_prefix && !brk && !ext;
    assign letter_d  = letter_decode(scan_code);
    assign digit_d   = digit_decode(scan_code);
    assign is_letter = make_code && letter_d[4];
    assign is_digit  = make_code && digit_d[4];
    assign is_enter  = make_code && (scan_code == KEY_ENTER);
    assign is_bksp   = make_code && (scan_code == KEY_BKSP);
    assign is_esc    = make_code && (scan_code == KEY_ESC);

    assign entry_open  = (state == GOT_LETTER) || (state == GOT_NUMBER);
    // A byte that arrives in the expiry cycle takes priority over the timeout.
    assign timeout_hit = entry_open && !scan_valid &&
                         (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

    assign entry_state = state;

    always_ff @(posedge clock27) begin
        if (reset) begin
            state      <= IDLE;
            brk        <= 1'b0;
            ext        <= 1'b0;
            idle_cnt   <= '0;
            cmd_valid  <= 1'b0;
            cmd_letter <= 4'd0;
            cmd_number <= 4'd0;
            entry_err  <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            entry_err <= 1'b0;
            timeout   <= 1'b0;

            // Prefix tracking continues in HOLD so that the stream stays aligned.
            if (scan_valid) begin
                if (scan_code == KEY_BREAK) begin
                    brk <= 1'b1;
                end else if (scan_code == KEY_EXTENDED) begin
                    ext <= 1'b1;
                end else begin
                    brk <= 1'b0;
                    ext <= 1'b0;
                end
            end

            if (scan_valid || !entry_open || timeout_hit) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + TW'(1);
            end

            case (state)
                IDLE: begin
                    if (is_letter) begin
                        cmd_letter <= letter_d[3:0];
                        state      <= GOT_LETTER;
                    end
                end
                GOT_LETTER: begin
                    if (timeout_hit) begin
                        timeout <= 1'b1;
                        state   <= IDLE;
                    end else if (is_digit) begin
                        cmd_number <= digit_d[3:0];
                        state      <= GOT_NUMBER;
                    end else if (is_letter) begin
                        cmd_letter <= letter_d[3:0];
                    end else if (is_bksp || is_esc) begin
                        state <= IDLE;
                    end else if (is_enter) begin
                        entry_err <= 1'b1;
                    end
                end
                GOT_NUMBER: begin
                    if (timeout_hit) begin
                        timeout <= 1'b1;
                        state   <= IDLE;
                    end else if (is_enter) begin
                        cmd_valid <= 1'b1;
                        state     <= HOLD;
                    end else if (is_digit) begin
                        cmd_number <= digit_d[3:0];
                    end else if (is_bksp) begin
                        state <= GOT_LETTER;
                    end else if (is_esc) begin
                        state <= IDLE;
                    end else if (is_letter) begin
                        entry_err <= 1'b1;
                    end
                end
                HOLD: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_entry_sequencer.sv
// Directed scenarios for key_entry_sequencer. A scoreboard queue holds the expected command, error and timeout events.
// A monitor on the falling edge pops that queue and compares each event the DUT produces.
module tb_key_entry_sequencer;

    localparam int EV_CMD = 0;
    localparam int EV_ERR = 1;
    localparam int EV_TO  = 2;

    typedef struct {
        int       kind;
        logic [3:0] letter;
        logic [3:0] number;
    } ev_t;

    logic       clock27 = 1'b0;
    logic       reset;
    logic       scan_valid;
    logic [7:0] scan_code;
    logic       cmd_ready;
    logic       cmd_valid;
    logic [3:0] cmd_letter;
    logic [3:0] cmd_number;
    logic [1:0] entry_state;
    logic       entry_err;
    logic       timeout;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  vcount   = 0;

    key_entry_sequencer #(.TIMEOUT_CYCLES(100), .TW(7)) dut (
        .clock27    (clock27),
        .reset      (reset),
        .scan_valid (scan_valid),
        .scan_code  (scan_code),
        .cmd_ready  (cmd_ready),
        .cmd_valid  (cmd_valid),
        .cmd_letter (cmd_letter),
        .cmd_number (cmd_number),
        .entry_state(entry_state),
        .entry_err  (entry_err),
        .timeout    (timeout)
    );

    always #5 clock27 = ~clock27;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [3:0] l, input logic [3:0] n);
        ev_t e;
        e.kind   = kind;
        e.letter = l;
        e.number = n;
        exp_q.push_back(e);
    endtask

    task automatic take_event(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d, expected none", kind);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", kind, e.kind);
            if (kind == EV_CMD && e.kind == EV_CMD) begin
                check("cmd_letter", cmd_letter, e.letter);
                check("cmd_number", cmd_number, e.number);
            end
        end
    endtask

    always @(negedge clock27) begin
        if (!reset) begin
            if (cmd_valid) vcount++;
            if (cmd_valid && cmd_ready) take_event(EV_CMD);
            if (entry_err) take_event(EV_ERR);
            if (timeout) take_event(EV_TO);
        end
    end

    task automatic send(input logic [7:0] b);
        scan_valid = 1'b1;
        scan_code  = b;
        @(posedge clock27);
        #1;
        scan_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock27);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got time limit, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int v0;
        reset      = 1'b1;
        scan_valid = 1'b0;
        scan_code  = 8'h00;
        cmd_ready  = 1'b0;
        idle(3);
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_letter", cmd_letter, 0);
        check("rst_number", cmd_number, 0);
        check("rst_state", entry_state, 0);
        check("rst_err", entry_err, 0);
        check("rst_timeout", timeout, 0);
        reset = 1'b0;
        idle(1);

        // T1: break codes stripped, ready already high
        cmd_ready = 1'b1;
        send(8'h1C);
        check("t1_state_letter", entry_state, 1);
        send(8'hF0);
        send(8'h1C);
        send(8'h16);
        check("t1_state_number", entry_state, 2);
        send(8'hF0);
        send(8'h16);
        v0 = vcount;
        push(EV_CMD, 4'd0, 4'd1);
        send(8'h5A);
        send(8'hF0);
        send(8'h5A);
        idle(2);
        check("t1_state_end", entry_state, 0);
        check("t1_valid_cycles", vcount - v0, 1);

        // T2: consumer stalls
        cmd_ready = 1'b0;
        send(8'h21);
        send(8'h3D);
        push(EV_CMD, 4'd2, 4'd7);
        send(8'h5A);
        send(8'h32);
        idle(10);
        check("t2_valid_held", cmd_valid, 1);
        check("t2_state_hold", entry_state, 3);
        check("t2_letter", cmd_letter, 2);
        check("t2_number", cmd_number, 7);
        cmd_ready = 1'b1;
        idle(1);
        check("t2_valid_drop", cmd_valid, 0);
        check("t2_state_idle", entry_state, 0);
        idle(2);
        check("t2_no_new_entry", entry_state, 0);

        // T3: backspace, esc, illegal enter
        send(8'h1C);
        send(8'h16);
        send(8'h66);
        check("t3_bksp", entry_state, 1);
        send(8'h45);
        push(EV_CMD, 4'd0, 4'd0);
        send(8'h5A);
        idle(2);
        check("t3_state_idle", entry_state, 0);
        send(8'h32);
        send(8'h76);
        check("t3_esc", entry_state, 0);
        push(EV_ERR, 4'd0, 4'd0);
        send(8'h24);
        send(8'h5A);
        check("t3_err_stay", entry_state, 1);
        send(8'h76);
        idle(2);

        // T4: keypad Enter is extended and must be ignored
        send(8'h1C);
        send(8'h16);
        send(8'hE0);
        send(8'h5A);
        idle(3);
        check("t4_state_number", entry_state, 2);
        check("t4_no_cmd", cmd_valid, 0);
        send(8'hE0);
        send(8'hF0);
        send(8'h5A);
        push(EV_CMD, 4'd0, 4'd1);
        send(8'h5A);
        idle(2);
        check("t4_state_end", entry_state, 0);

        // T5: timeout, then a byte in the expiry cycle
        send(8'h3B);
        push(EV_TO, 4'd0, 4'd0);
        idle(99);
        check("t5_pre_state", entry_state, 1);
        check("t5_pre_timeout", timeout, 0);
        idle(1);
        check("t5_timeout", timeout, 1);
        check("t5_state_idle", entry_state, 0);
        idle(2);
        send(8'h3B);
        idle(99);
        send(8'h16);
        check("t5_byte_wins", timeout, 0);
        check("t5_byte_state", entry_state, 2);
        idle(1);
        check("t5_no_late_to", timeout, 0);
        send(8'h76);
        idle(2);
        check("t5_state_end", entry_state, 0);

        // T6: reset during HOLD
        cmd_ready = 1'b0;
        send(8'h1C);
        send(8'h16);
        send(8'h5A);
        check("t6_hold_valid", cmd_valid, 1);
        check("t6_hold_state", entry_state, 3);
        reset = 1'b1;
        idle(1);
        check("t6_rst_valid", cmd_valid, 0);
        check("t6_rst_state", entry_state, 0);
        reset = 1'b0;
        idle(5);

        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
